// File: rtl/shot_scheduler.sv
// Battleship shot scheduler: alternates player/PC turns, runs each shot as a
// read-check-write sequence on the board memory, and tracks remaining ships.
module shot_scheduler #(
  parameter logic [15:0] TURN_CYCLES = 16'd5000,
  parameter logic [4:0]  SHIP_CELLS  = 5'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p_req,
  input  logic [5:0] p_addr,
  input  logic       pc_req,
  input  logic [5:0] pc_addr,
  input  logic [1:0] mem_rdata,
  output logic [6:0] mem_addr,
  output logic       mem_we,
  output logic [1:0] mem_wdata,
  output logic       p_gnt,
  output logic       pc_gnt,
  output logic       turn,
  output logic       hit,
  output logic       reject,
  output logic       done,
  output logic       timeout,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_P, S_WAIT_PC, S_READ, S_CHECK, S_WRITE, S_END
  } state_t;

  state_t      state, state_d;
  logic [15:0] timer;
  logic [4:0]  left_p, left_pc;
  logic [6:0]  addr_q;     // {target board, cell}; board 1 means the player is shooting
  logic [1:0]  wdata_q;
  logic        ship_q;
  logic        turn_q, winner_q;
  logic [4:0]  tgt_left;
  logic        turn_expired;

  assign tgt_left     = addr_q[6] ? left_pc : left_p;
  // Timer never passes TURN_CYCLES-1 because it only advances on idle cycles;
  // >= is a guard rather than a functional requirement.
  assign turn_expired = (timer >= TURN_CYCLES - 16'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic and the combinational pulses that depend on live inputs
  always_comb begin
    state_d = state;
    p_gnt   = 1'b0;
    pc_gnt  = 1'b0;
    timeout = 1'b0;
    reject  = 1'b0;
    case (state)
      S_IDLE:    if (start) state_d = S_WAIT_P;
      S_WAIT_P: begin
        if (p_req) begin
          p_gnt   = 1'b1;
          state_d = S_READ;
        end else if (turn_expired) begin
          timeout = 1'b1;
          state_d = S_WAIT_PC;
        end
      end
      S_WAIT_PC: begin
        if (pc_req) begin
          pc_gnt  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ:    state_d = S_CHECK;
      S_CHECK: begin
        if (mem_rdata[1]) begin
          // Cell already shot: bounce back to the same shooter's wait state
          reject  = 1'b1;
          state_d = addr_q[6] ? S_WAIT_P : S_WAIT_PC;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ship_q && tgt_left == 5'd0) state_d = S_END;
        else                            state_d = addr_q[6] ? S_WAIT_PC : S_WAIT_P;
      end
      S_END:     state_d = S_END;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: target latch, write data, ship counters, turn timer, winner
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      left_p   <= '0;
      left_pc  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ship_q   <= 1'b0;
      turn_q   <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            left_p  <= SHIP_CELLS;
            left_pc <= SHIP_CELLS;
            timer   <= '0;
            turn_q  <= 1'b0;
          end
        end
        S_WAIT_P: begin
          if (p_req) begin
            addr_q <= {1'b1, p_addr};
          end else if (turn_expired) begin
            timer  <= '0;
            turn_q <= 1'b1;
          end else begin
            timer  <= timer + 16'd1;
          end
        end
        S_WAIT_PC: if (pc_req) addr_q <= {1'b0, pc_addr};
        S_CHECK: begin
          if (!mem_rdata[1]) begin
            // water -> miss (10), ship -> hit (11)
            wdata_q <= {1'b1, mem_rdata[0]};
            ship_q  <= mem_rdata[0];
            if (mem_rdata[0]) begin
              if (addr_q[6]) begin
                if (left_pc != 5'd0) left_pc <= left_pc - 5'd1;
              end else begin
                if (left_p != 5'd0) left_p <= left_p - 5'd1;
              end
            end
          end
        end
        S_WRITE: begin
          if (ship_q && tgt_left == 5'd0) begin
            winner_q <= ~addr_q[6];
          end else begin
            turn_q <= ~turn_q;
            timer  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; the write strobe is also masked by rst so a reset edge never writes
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state == S_WRITE) && !rst;
  assign done      = (state == S_WRITE);
  assign hit       = (state == S_WRITE) && ship_q;
  assign turn      = turn_q;
  assign game_over = (state == S_END);
  assign winner    = winner_q;

endmodule
